// File: rtl/radix_pkg.sv
// Shared encodings for the radix mode controller: mode values, the blank
// segment pattern, digit-enable codes and the mode sequencing helper.
package radix_pkg;

    typedef enum logic [1:0] {
        MODE_OCT = 2'b00,
        MODE_DEC = 2'b01,
        MODE_HEX = 2'b10,
        MODE_BAD = 2'b11
    } mode_t;

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    localparam logic [1:0] DIG_NONE = 2'b00;
    localparam logic [1:0] DIG_LO   = 2'b01;
    localparam logic [1:0] DIG_HI   = 2'b10;

    // Next radix in the OCT -> DEC -> HEX -> OCT rotation; the illegal
    // code folds back to OCT so a corrupted state always recovers.
    function automatic mode_t mode_step(input mode_t m);
        case (m)
            MODE_OCT: mode_step = MODE_DEC;
            MODE_DEC: mode_step = MODE_HEX;
            default:  mode_step = MODE_OCT;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, counter debouncer and a
// single-cycle press pulse on each accepted 0->1 change of the level.
module btn_debounce
    import radix_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_press;
    logic [DB_W-1:0] r_cnt;

    // Synchronize the raw button, then accept a new level only after an
    // unbroken run of differing samples; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/radix_mode_ctrl.sv
// Radix mode controller: debounced mode button (optionally plus an auto
// timer) steps the OCT/DEC/HEX mode, and a two-digit multiplexed display is
// scanned with a blank interval after every mode change so the external
// converter can settle. Optional auto cycling: define RADIX_AUTO_CYCLE_EN.
module radix_mode_ctrl
    import radix_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SCAN_CYCLES     = 50000,
    parameter int AUTO_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       auto_en,
    input  logic [6:0] seg_lo,
    input  logic [6:0] seg_hi,
    output logic [1:0] mode,
    output logic       mode_chg,
    output logic [6:0] seg_out,
    output logic [1:0] digit_en
);

    localparam int SC_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    logic            w_press;
    logic            w_btn_level_unused;
    logic            w_tick;
    logic            w_advance;
    logic            w_chg;
    mode_t           r_state;
    mode_t           w_state_next;
    logic            r_mode_chg;
    logic [SC_W-1:0] r_scan_cnt;
    logic [SC_W-1:0] w_scan_next;
    logic            r_slot;
    logic            w_slot_next;
    logic            r_blank;
    logic            w_blank_next;
    logic [6:0]      r_seg;
    logic [1:0]      r_dig;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (mode_btn),
        .o_level(w_btn_level_unused),
        .o_press(w_press)
    );

`ifdef RADIX_AUTO_CYCLE_EN
    localparam int AU_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;

    logic [AU_W-1:0] r_auto_cnt;

    assign w_tick = auto_en && (r_auto_cnt == AU_W'(AUTO_CYCLES - 1));

    // Auto timer: restarts on every advance (manual or automatic) and is
    // held at zero while auto cycling is disabled.
    always_ff @(posedge clk) begin
        if (rst || !auto_en || w_advance) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + 1'b1;
        end
    end
`else
    logic w_auto_en_unused;

    assign w_auto_en_unused = auto_en;
    assign w_tick           = 1'b0;
`endif

    // A press and an auto tick in the same cycle merge into one advance.
    assign w_advance = w_press | w_tick;

    // Mode state register; mode_chg is registered alongside so it pulses in
    // exactly the cycle the new mode appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= MODE_OCT;
            r_mode_chg <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_mode_chg <= w_chg;
        end
    end

    // Mode next-state: rotate on advance, force the illegal code back to OCT.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MODE_BAD: w_state_next = MODE_OCT;
            default:  if (w_advance) w_state_next = mode_step(r_state);
        endcase
    end

    assign w_chg = (w_state_next != r_state);

    // Scan/blank next-state: a mode change restarts the slot timer in a blank
    // interval, which then hands over to a fresh low slot.
    always_comb begin
        w_scan_next  = r_scan_cnt;
        w_slot_next  = r_slot;
        w_blank_next = r_blank;
        if (w_chg) begin
            w_scan_next  = '0;
            w_slot_next  = 1'b0;
            w_blank_next = 1'b1;
        end else if (r_scan_cnt == SC_W'(SCAN_CYCLES - 1)) begin
            w_scan_next = '0;
            if (r_blank) begin
                w_blank_next = 1'b0;
                w_slot_next  = 1'b0;
            end else begin
                w_slot_next = ~r_slot;
            end
        end else begin
            w_scan_next = r_scan_cnt + 1'b1;
        end
    end

    // Scan registers and the registered display bus, driven from the slot
    // being entered so blank and slot lengths are exactly SCAN_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_slot     <= 1'b0;
            r_blank    <= 1'b0;
            r_seg      <= SEG_BLANK;
            r_dig      <= DIG_NONE;
        end else begin
            r_scan_cnt <= w_scan_next;
            r_slot     <= w_slot_next;
            r_blank    <= w_blank_next;
            if (w_blank_next) begin
                r_seg <= SEG_BLANK;
                r_dig <= DIG_NONE;
            end else if (w_slot_next) begin
                r_seg <= seg_hi;
                r_dig <= DIG_HI;
            end else begin
                r_seg <= seg_lo;
                r_dig <= DIG_LO;
            end
        end
    end

    assign mode     = r_state;
    assign mode_chg = r_mode_chg;
    assign seg_out  = r_seg;
    assign digit_en = r_dig;

endmodule

// File: tb/tb_radix_mode_ctrl.sv
// Self-checking bench for radix_mode_ctrl with short debounce/scan/auto
// periods. Expected modes (and, for auto cycling, expected cycles) are queued
// when stimulus is applied and popped when mode_chg is observed.
module tb_radix_mode_ctrl;
    import radix_pkg::*;

    localparam int DB = 4;
    localparam int SC = 8;
    localparam int AC = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_btn = 1'b0;
    logic       auto_en = 1'b0;
    logic [6:0] seg_lo = 7'h3F;
    logic [6:0] seg_hi = 7'h06;
    logic [1:0] mode;
    logic       mode_chg;
    logic [6:0] seg_out;
    logic [1:0] digit_en;

    int errors = 0;
    int checks = 0;
    int chg_total = 0;
    logic [1:0] exp_mode = 2'b00;
    logic [1:0] exp_q[$];
    int         cyc_q[$];

    radix_mode_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .SCAN_CYCLES    (SC),
        .AUTO_CYCLES    (AC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode_btn(mode_btn),
        .auto_en (auto_en),
        .seg_lo  (seg_lo),
        .seg_hi  (seg_hi),
        .mode    (mode),
        .mode_chg(mode_chg),
        .seg_out (seg_out),
        .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (mode_chg === 1'b1) chg_total++;
    end

    function automatic logic [1:0] nxt(input logic [1:0] m);
        case (m)
            2'b00:   nxt = 2'b01;
            2'b01:   nxt = 2'b10;
            default: nxt = 2'b00;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        mode_btn = 1'b0;
        auto_en = 1'b0;
        seg_lo = 7'h3F;
        seg_hi = 7'h06;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_mode = 2'b00;
        exp_q.delete();
        cyc_q.delete();
    endtask

    task automatic wait_chg(input int limit, output bit found, output int n);
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (mode_chg === 1'b1) begin
                found = 1'b1;
                n = i;
                break;
            end
        end
    endtask

    task automatic drive_btn(input int len);
        fork
            begin
                mode_btn = 1'b1;
                repeat (len) @(negedge clk);
                mode_btn = 1'b0;
            end
        join_none
    endtask

    // Push the expected mode, press, and pop/compare on the observed pulse.
    task automatic press_and_pop(input string name, input int len);
        bit found;
        int n;
        logic [1:0] e;
        exp_mode = nxt(exp_mode);
        exp_q.push_back(exp_mode);
        drive_btn(len);
        wait_chg(30, found, n);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_timeout: mode_chg seen=0 required=1", name);
        end else begin
            checks++;
            if (mode !== e) begin
                errors++;
                $display("FAIL %s_mode: got %b expected %b", name, mode, e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mode, mode_chg, seg_out, digit_en} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got mode=%b chg=%b seg=%h de=%b expected all zero",
                     mode, mode_chg, seg_out, digit_en);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (digit_en !== 2'b01 || seg_out !== 7'h3F) begin
            errors++;
            $display("FAIL reset_first_slot: got de=%b seg=%h expected de=01 seg=3f", digit_en, seg_out);
        end
    endtask

    task automatic test_scan();
        logic [1:0] e_de;
        logic [6:0] e_seg;
        logic [6:0] lo_v;
        logic [6:0] hi_v;
        do_reset();
        lo_v = 7'h3F;
        hi_v = 7'h06;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            e_de = (((k / SC) % 2) == 1) ? 2'b10 : 2'b01;
            e_seg = (e_de == 2'b10) ? hi_v : lo_v;
            checks++;
            if (digit_en !== e_de || seg_out !== e_seg || mode !== 2'b00) begin
                errors++;
                $display("FAIL scan_k%0d: got de=%b seg=%h mode=%b expected de=%b seg=%h mode=00",
                         k, digit_en, seg_out, mode, e_de, e_seg);
            end
            if (k == 20) begin
                seg_lo = 7'h5B;
                seg_hi = 7'h4F;
                lo_v = 7'h5B;
                hi_v = 7'h4F;
            end
        end
    endtask

    task automatic test_press();
        int c0;
        do_reset();
        repeat (20) @(negedge clk);
        c0 = chg_total;
        press_and_pop("press", 10);
        for (int i = 0; i < SC; i++) begin
            checks++;
            if (digit_en !== 2'b00 || seg_out !== 7'h00) begin
                errors++;
                $display("FAIL press_blank_%0d: got de=%b seg=%h expected de=00 seg=00", i, digit_en, seg_out);
            end
            @(negedge clk);
        end
        checks++;
        if (digit_en !== 2'b01 || seg_out !== 7'h3F) begin
            errors++;
            $display("FAIL press_after_blank: got de=%b seg=%h expected de=01 seg=3f", digit_en, seg_out);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (chg_total - c0 !== 1) begin
            errors++;
            $display("FAIL press_count: got %0d pulses expected 1", chg_total - c0);
        end
    endtask

    task automatic test_bounce();
        int c0;
        bit found;
        int n;
        logic [1:0] e;
        do_reset();
        repeat (10) @(negedge clk);
        c0 = chg_total;
        for (int i = 0; i < 6; i++) begin
            mode_btn = (i % 2 == 0);
            @(negedge clk);
        end
        exp_mode = nxt(exp_mode);
        exp_q.push_back(exp_mode);
        mode_btn = 1'b1;
        wait_chg(20, found, n);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
        checks++;
        if (!found || n < DB + 1 || n > DB + 3 || mode !== e) begin
            errors++;
            $display("FAIL bounce_advance: got found=%0d delay=%0d mode=%b expected delay %0d..%0d mode=%b",
                     found, n, mode, DB + 1, DB + 3, e);
        end
        repeat (10) @(negedge clk);
        mode_btn = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (chg_total - c0 !== 1) begin
            errors++;
            $display("FAIL bounce_count: got %0d pulses expected 1", chg_total - c0);
        end
    endtask

    task automatic test_sequence_and_illegal();
        bit found;
        int n;
        do_reset();
        repeat (10) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            press_and_pop($sformatf("seq%0d", p), 10);
            repeat (25) @(negedge clk);
        end
        // Mid-blank, corrupt the state: recovery must pulse mode_chg and
        // restart the blank interval.
        press_and_pop("seq3", 6);
        repeat (3) @(negedge clk);
        force dut.r_state = MODE_BAD;
        @(posedge clk);
        #1;
        checks++;
        if (mode_chg !== 1'b1 || digit_en !== 2'b00) begin
            errors++;
            $display("FAIL illegal_recover: got chg=%b de=%b expected chg=1 de=00", mode_chg, digit_en);
        end
        release dut.r_state;
        exp_mode = 2'b00;
        repeat (7) @(negedge clk);
        checks++;
        if (digit_en !== 2'b00 || mode !== 2'b00) begin
            errors++;
            $display("FAIL blank_restart: got de=%b mode=%b expected de=00 mode=00", digit_en, mode);
        end
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (digit_en === 2'b01) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || seg_out !== 7'h3F) begin
            errors++;
            $display("FAIL blank_restart_end: got found=%0d seg=%h expected 1 seg=3f", found, seg_out);
        end
        wait_chg(1, found, n);
    endtask

    task automatic test_reset_mid();
        bit found;
        int n;
        do_reset();
        repeat (10) @(negedge clk);
        press_and_pop("mid_press", 10);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mode, mode_chg, seg_out, digit_en} !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset: got mode=%b chg=%b seg=%h de=%b expected all zero",
                     mode, mode_chg, seg_out, digit_en);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (digit_en !== 2'b01 || mode !== 2'b00) begin
            errors++;
            $display("FAIL mid_release: got de=%b mode=%b expected de=01 mode=00", digit_en, mode);
        end
        repeat (10) @(negedge clk);
        // Button held through reset must still register a single press.
        rst = 1'b1;
        mode_btn = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_chg(DB + 4, found, n);
        checks++;
        if (!found || mode !== 2'b01) begin
            errors++;
            $display("FAIL held_reset: got found=%0d mode=%b expected 1 mode=01", found, mode);
        end
        mode_btn = 1'b0;
        repeat (20) @(negedge clk);
    endtask

`ifdef RADIX_AUTO_CYCLE_EN
    task automatic auto_run(input string name, input int cycles, input int press_at);
        logic [1:0] e;
        int ec;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clk);
            if (k == press_at) mode_btn = 1'b1;
            if (k == press_at + 10) mode_btn = 1'b0;
            if (mode_chg === 1'b1) begin
                ec = (cyc_q.size() > 0) ? cyc_q.pop_front() : -1;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
                checks++;
                if (k !== ec || mode !== e) begin
                    errors++;
                    $display("FAIL %s_adv: got cycle=%0d mode=%b expected cycle=%0d mode=%b", name, k, mode, ec, e);
                end
            end
        end
        checks++;
        if (cyc_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: got %0d advances pending expected 0", name, cyc_q.size());
        end
        auto_en = 1'b0;
        mode_btn = 1'b0;
    endtask

    task automatic test_auto();
        do_reset();
        for (int j = 1; j <= 3; j++) begin
            exp_mode = nxt(exp_mode);
            exp_q.push_back(exp_mode);
            cyc_q.push_back(j * AC);
        end
        auto_en = 1'b1;
        auto_run("auto", 200, -100);
        do_reset();
        for (int j = 1; j <= 2; j++) begin
            exp_mode = nxt(exp_mode);
            exp_q.push_back(exp_mode);
            cyc_q.push_back(j * AC);
        end
        auto_en = 1'b1;
        // Button raised here lands its debounced press on the same edge as
        // the first auto tick.
        auto_run("coincide", 140, AC - DB - 3);
    endtask
`else
    task automatic test_auto();
        int c0;
        do_reset();
        c0 = chg_total;
        auto_en = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (chg_total - c0 !== 0 || mode !== 2'b00) begin
            errors++;
            $display("FAIL auto_ignored: got %0d pulses mode=%b expected 0 pulses mode=00",
                     chg_total - c0, mode);
        end
        auto_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_press();
        test_bounce();
        test_sequence_and_illegal();
        test_reset_mid();
        test_auto();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/radix_mode_ctrl.md
RADIX_MODE_CTRL -- requirements
Module: radix_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable synchronized samples required to accept a new button level.
REQ-002 Parameter SCAN_CYCLES, default 50000: clock cycles per display digit slot.
REQ-003 Parameter AUTO_CYCLES, default 50000000: clock cycles between automatic mode advances.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mode_btn  input  1  raw, asynchronous, bouncing mode pushbutton (replaces combinational mealy_switch edge detection).
REQ-007 auto_en  input  1  level; enables automatic mode cycling (see Configuration).
REQ-008 seg_lo  input  7  segment pattern of low digit for the currently selected radix.
REQ-009 seg_hi  input  7  segment pattern of high digit for the currently selected radix.
REQ-010 mode  output  2  selected radix: 00 octal, 01 decimal, 10 hexadecimal; drives the external converter mux.
REQ-011 mode_chg  output  1  one-cycle pulse in the cycle mode takes a new value.
REQ-012 seg_out  output  7  registered, time-multiplexed segment bus shared by both digits.
REQ-013 digit_en  output  2  one-hot digit enable: 01 low digit, 10 high digit, 00 blank.

Function
REQ-014 mode_btn SHALL pass a 2-flop synchronizer before any other use.
REQ-015 Debouncer SHALL update its debounced level only after DEBOUNCE_CYCLES consecutive cycles of synchronized value differing from it; any sample equal to the current level SHALL clear the counter.
REQ-016 A press SHALL be a 0->1 transition of the debounced level; releases SHALL generate nothing.
REQ-017 Mode FSM SHALL step OCT(00)->DEC(01)->HEX(10)->OCT on each advance event; mode SHALL update in the cycle after the press is detected and mode_chg SHALL pulse in that same cycle.
REQ-018 State 11 SHALL be unreachable; if entered, FSM SHALL return to OCT on the next cycle and pulse mode_chg.
REQ-019 Scan counter SHALL wrap every SCAN_CYCLES cycles, alternating slots low, high, low, ...; seg_out/digit_en SHALL be registered with one-cycle latency from seg_lo/seg_hi.
REQ-020 Low slot: seg_out=seg_lo, digit_en=01; high slot: seg_out=seg_hi, digit_en=10.
REQ-021 On mode_chg the scan counter SHALL restart at the low slot and output SHALL blank (seg_out=0000000, digit_en=00) for exactly SCAN_CYCLES cycles, allowing the converter outputs to settle.
REQ-022 A mode_chg during an active blank interval SHALL restart the blank interval.
REQ-023 Simultaneous manual press and auto tick in the same cycle SHALL produce exactly one advance.

Reset
REQ-024 While rst is high: mode=00, mode_chg=0, seg_out=0000000, digit_en=00, synchronizer flops=0, debounced level=0, all counters=0.
REQ-025 The first cycle after rst deasserts SHALL begin a low slot; digit_en=01 one cycle later.
REQ-026 A button held through reset SHALL register one press DEBOUNCE_CYCLES+3 cycles after reset release at the latest.
REQ-027 Reset asserted mid-debounce, mid-blank or mid-scan SHALL discard all progress.

Configuration
REQ-028 Macro RADIX_AUTO_CYCLE_EN defined: an auto timer SHALL advance mode every AUTO_CYCLES cycles while auto_en=1, SHALL clear on any advance or when auto_en=0.
REQ-029 Macro RADIX_AUTO_CYCLE_EN undefined: no auto timer logic; auto_en port SHALL remain but be ignored; mode changes only on presses.

Structure
REQ-030 Shared package radix_pkg SHALL hold the mode encoding (MODE_OCT, MODE_DEC, MODE_HEX), the blank segment constant and the digit_en encodings.
REQ-031 Synchronizer+debouncer SHALL be the sub-module btn_debounce (outputs debounced level and press pulse); the FSM, scan and blanking logic remain in radix_mode_ctrl.

Verification (DEBOUNCE_CYCLES=4, SCAN_CYCLES=8, AUTO_CYCLES=64)
REQ-032 Reset then idle -> mode=00, digit_en alternates 01/10 every 8 cycles, seg_out follows seg_lo=7'h3F / seg_hi=7'h06.
REQ-033 Clean press of 10 cycles -> exactly one mode_chg, mode 00->01, then 8 cycles of digit_en=00 and seg_out=0.
REQ-034 Bounce of 1-cycle pulses alternating for 6 cycles, then stable high -> no press during bounce, exactly one advance afterward.
REQ-035 Three clean presses -> mode sequence 01,10,00; force FSM to 11 -> returns to 00 next cycle with mode_chg=1.
REQ-036 Macro defined, auto_en=1 for 200 cycles -> advances at cycles 64,128,192 (timer restart after each); press coinciding with tick -> single advance.
REQ-037 rst pulsed during blank interval -> all outputs at REQ-024 values, digit_en=01 two cycles after release.
